// File: rtl/keypad_pkg.sv
// Shared types and constants for the keypad press path.
// Used by the press controller and its debounce counter.
package keypad_pkg;

   localparam int KEY_W = 4;

   localparam logic [KEY_W-1:0] DIGIT_RST = 4'h0;

   typedef enum logic [1:0] {
      IDLE,
      PRESS_DB,
      HELD,
      REL_DB
   } press_state_t;

endpackage

// File: rtl/keypad_press_controller_debounce_counter.sv
// Clear/enable stability counter for the press controller.
// tc flags the last count before a press or release is accepted.
module debounce_counter #(
   parameter  int DEBOUNCE_CYCLES = 4,
   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES)
) (
   input  logic clk,
   input  logic nreset,
   input  logic clr,
   input  logic en,
   output logic tc
);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!nreset || clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   // tc is checked before incrementing, so cnt never wraps
   assign tc = (cnt == CNT_W'(DEBOUNCE_CYCLES - 1));

endmodule

// File: rtl/keypad_press_controller.sv
// Turns bouncy keypad samples into one-shot presses and
// freezes the scanner while a key is qualified or held.
module keypad_press_controller
   import keypad_pkg::*;
#(
   parameter  int DEBOUNCE_CYCLES = 4,
   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES)
) (
   input  logic             clk,
   input  logic             nreset,
   input  logic [KEY_W-1:0] key_code,
   input  logic             key_valid,
   output logic             scan_hold,
   output logic             press_pulse,
   output logic [KEY_W-1:0] press_code,
   output logic [KEY_W-1:0] digit_new,
   output logic [KEY_W-1:0] digit_old
);

   press_state_t     state;
   logic [KEY_W-1:0] cand;
   logic             match;
   logic             tc;
   logic             cnt_en;
   logic             cnt_clr;

   assign match = key_valid && (key_code == cand);

   // Counter runs only while stability is still being proven
   always_comb begin
      cnt_en = 1'b0;
      unique case (1'b1)
         (state == PRESS_DB): cnt_en = match && !tc;
         (state == REL_DB):   cnt_en = !match && !tc;
         default:             cnt_en = 1'b0;
      endcase
   end

   assign cnt_clr = !cnt_en;

   debounce_counter #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_cnt (
      .clk   (clk),
      .nreset(nreset),
      .clr   (cnt_clr),
      .en    (cnt_en),
      .tc    (tc)
   );

   always_ff @(posedge clk) begin
      if (!nreset) begin
         state       <= IDLE;
         cand        <= '0;
         scan_hold   <= 1'b0;
         press_pulse <= 1'b0;
         press_code  <= '0;
         digit_new   <= DIGIT_RST;
         digit_old   <= DIGIT_RST;
      end else begin
         press_pulse <= 1'b0;
         case (state)
            IDLE: begin
               if (key_valid) begin
                  cand      <= key_code;
                  state     <= PRESS_DB;
                  scan_hold <= 1'b1;
               end
            end
            PRESS_DB: begin
               if (match && tc) begin
                  state       <= HELD;
                  press_pulse <= 1'b1;
                  press_code  <= cand;
                  digit_old   <= digit_new;
                  digit_new   <= cand;
               end else if (!match) begin
                  state     <= IDLE;
                  scan_hold <= 1'b0;
               end
            end
            HELD: begin
               if (!match) begin
                  state <= REL_DB;
               end
            end
            REL_DB: begin
               if (match) begin
                  state <= HELD;
               end else if (tc) begin
                  state     <= IDLE;
                  scan_hold <= 1'b0;
               end
            end
            default: begin
               state     <= IDLE;
               scan_hold <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/keypad_press_controller.md
Name: keypad_press_controller

Overview:
Sequences the 4x4 keypad column scanner and turns its raw, bouncy per-cycle key samples into clean one-shot key-press events. It pauses the scanner on the active column while a key is being qualified or held, debounces both press and release, and maintains a two-digit history (newest and previous key) for the dual seven-segment display path. It sits between the keypad decoder and the display multiplexer.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive stable samples required to accept a press or a release; must be >= 2; use 50000 for hardware and 4 for simulation.
CNT_W, $clog2(DEBOUNCE_CYCLES), width of the debounce counter; derived, not overridden.

Ports:
clk  in  1  system clock
nreset  in  1  synchronous active-low reset
key_code  in  4  hex code of the key currently decoded by the scanner
key_valid  in  1  key_code is a legal single-key decode this cycle
scan_hold  out  1  1 = scanner must freeze on its current column
press_pulse  out  1  single-cycle strobe marking an accepted key press
press_code  out  4  code of the last accepted press; held until the next press
digit_new  out  4  most recently accepted key
digit_old  out  4  key accepted before digit_new

Behaviour:
- Reset: nreset=0 sampled on posedge clk. Forces state=IDLE, cnt=0, cand=0, scan_hold=0, press_pulse=0, press_code=0, digit_new=0, digit_old=0. Reset in any state, including mid-debounce, discards the candidate with no pulse.
- All outputs are registered. scan_hold is a Moore output: it is 1 in every state except IDLE.
- "match" = key_valid && key_code==cand.
- State IDLE: if key_valid, then cand<=key_code, cnt<=0, go to PRESS_DB. Otherwise stay.
- State PRESS_DB:
  - If match and cnt==DEBOUNCE_CYCLES-1: go to HELD. On the same edge set press_pulse<=1, press_code<=cand, digit_old<=digit_new, digit_new<=cand.
  - Else if match: cnt<=cnt+1.
  - Else (no match): go to IDLE, cnt<=0, no pulse, digits unchanged.
- State HELD:
  - If match: stay.
  - Else: cnt<=0, go to REL_DB.
  - A second key, or a two-key invalid decode, counts as not-match. A new code is never accepted without first passing back through IDLE.
- State REL_DB:
  - If match: go to HELD, cnt<=0. This is release bounce and produces no new pulse.
  - Else if cnt==DEBOUNCE_CYCLES-1: go to IDLE, cnt<=0.
  - Else: cnt<=cnt+1.
- press_pulse is high for exactly 1 cycle per accepted press. It is cleared on every edge where it was not being set.
- Press latency: the first key_valid is sampled at edge E0. press_pulse and the updated digits are visible after edge E0+DEBOUNCE_CYCLES, provided there are DEBOUNCE_CYCLES consecutive matches starting at edge E0+1.
- Release latency: after the last match, DEBOUNCE_CYCLES+1 edges elapse before IDLE is reached and scan_hold drops.
- Counter never wraps: it is cleared on every state entry and compared against DEBOUNCE_CYCLES-1 before incrementing.
- Holding a key indefinitely produces a single pulse (no auto-repeat).
- Unused states in the 2-bit encoding return to IDLE with cnt<=0.

Decomposition:
- Package keypad_pkg holds:
  - the typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, REL_DB} press_state_t;
  - the key-code width constant KEY_W=4;
  - the reset digit value DIGIT_RST=4'h0.
- One sub-module, debounce_counter, provides the clear/enable counter with a terminal-count flag at DEBOUNCE_CYCLES-1. The FSM, candidate register and digit shift stay in keypad_press_controller.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4.
1. Reset, then hold key_valid=0 for 10 cycles -> all outputs 0, scan_hold=0, press_pulse never asserted.
2. Clean press: key_code=5, key_valid=1 held steady -> scan_hold=1 after 1 edge; press_pulse=1 for exactly one cycle 4 edges after first sample; digit_new=5, digit_old=0, press_code=5. Then key_valid=0 -> scan_hold drops 5 edges after the last match.
3. Press bounce: key_code=A valid for 2 cycles, invalid for 1, then valid steady -> no pulse from the first burst; one pulse counted from the re-entry into PRESS_DB; digit_new=A.
4. Release bounce: with 3 held, drop key_valid for 2 cycles, restore for 1 cycle, then drop for 6 cycles -> state goes back to HELD, no second pulse, IDLE reached once, digits unchanged.
5. Sequence: press and release 7, then press and release C -> exactly 2 pulses; final digit_new=C, digit_old=7.
6. Mid-operation reset: nreset=0 during PRESS_DB of key 9, and again during HELD of key 2 -> no pulse, digits forced to 0, scan_hold=0 on the next cycle; a following clean press of 4 gives digit_new=4, digit_old=0.
